// File: rtl/uart_ctrl_v2.sv
// Full-duplex UART core: programmable baud divisor, RX/TX FSMs and show-ahead FIFOs.
// Define UART_PARITY_EN to add a parity bit (parity_odd selects odd/even).

module uart_ctrl_v2_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_i,
  input  logic [W-1:0]  w_data_i,
  input  logic          rd_i,
  output logic [W-1:0]  r_data_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   level_o
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [W-1:0] mem_q [2**AW];
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic         do_wr, do_rd;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (level_o == '0);
  assign full_o  = (level_o == DEPTH);
  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign do_rd   = rd_i & ~empty_o;
  assign do_wr   = wr_i & (~full_o | do_rd);

  // NOTE: the reset sits inside the clocked block, so it only acts on a clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; empty_o masks stale words at the head.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= w_data_i;
  end

  assign r_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
endmodule

module uart_ctrl_v2 #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR_W  = 16,
  parameter int FIFO_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
`ifdef UART_PARITY_EN
  input  logic              parity_odd,
`endif
  input  logic              rx,
  output logic              tx,
  input  logic              wr_uart,
  input  logic [DBIT-1:0]   w_data,
  output logic              tx_full,
  output logic [FIFO_W:0]   tx_level,
  output logic              tx_busy,
  input  logic              rd_uart,
  output logic [DBIT-1:0]   r_data,
  output logic              r_frame_err,
  output logic              r_parity_err,
  output logic              rx_empty,
  output logic [FIFO_W:0]   rx_level,
  output logic              rx_overrun,
  input  logic              clr_overrun
);
  localparam int SW = $clog2(SB_TICK);
  localparam int NW = $clog2(DBIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  // Baud tick generator; an out-of-range count after a divisor change wraps at once.
  logic [DVSR_W-1:0] baud_q, baud_d, dvsr_m1;
  logic              tick;

  assign dvsr_m1 = (dvsr == '0) ? '0 : dvsr - DVSR_W'(1);
  assign tick    = (baud_q == dvsr_m1);
  assign baud_d  = (baud_q >= dvsr_m1) ? '0 : baud_q + DVSR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) baud_q <= '0;
    else       baud_q <= baud_d;
  end

  // Receiver
  logic            rx_s1_q, rx_s2_q;
  state_e          rx_state_q;
  logic [SW-1:0]   rx_s_q;
  logic [NW-1:0]   rx_n_q;
  logic [DBIT-1:0] rx_b_q;
  logic            rx_push, rx_ferr, rx_perr, rx_full;
  logic [DBIT+1:0] rx_head;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
    end
  end

`ifdef UART_PARITY_EN
  logic rx_par_q;
  assign rx_perr = rx_par_q ^ (^rx_b_q) ^ parity_odd;
`else
  assign rx_perr = 1'b0;
`endif
  assign rx_ferr = ~rx_s2_q;
  assign rx_push = (rx_state_q == S_STOP) && tick && (rx_s_q == SW'(SB_TICK-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= S_IDLE;
      rx_s_q     <= '0;
      rx_n_q     <= '0;
      rx_b_q     <= '0;
`ifdef UART_PARITY_EN
      rx_par_q   <= 1'b0;
`endif
    end else begin
      case (rx_state_q)
        S_IDLE: if (!rx_s2_q) begin
          rx_state_q <= S_START;
          rx_s_q     <= '0;
        end
        S_START: if (tick) begin
          // Mid-start-bit recheck rejects short low glitches.
          if (rx_s_q == SW'(7)) begin
            rx_s_q     <= '0;
            rx_n_q     <= '0;
            rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
          end else rx_s_q <= rx_s_q + SW'(1);
        end
        S_DATA: if (tick) begin
          if (rx_s_q == SW'(15)) begin
            rx_s_q <= '0;
            rx_b_q <= {rx_s2_q, rx_b_q[DBIT-1:1]};
            if (rx_n_q == NW'(DBIT-1)) begin
`ifdef UART_PARITY_EN
              rx_state_q <= S_PARITY;
`else
              rx_state_q <= S_STOP;
`endif
            end else rx_n_q <= rx_n_q + NW'(1);
          end else rx_s_q <= rx_s_q + SW'(1);
        end
`ifdef UART_PARITY_EN
        S_PARITY: if (tick) begin
          if (rx_s_q == SW'(15)) begin
            rx_s_q     <= '0;
            rx_par_q   <= rx_s2_q;
            rx_state_q <= S_STOP;
          end else rx_s_q <= rx_s_q + SW'(1);
        end
`endif
        S_STOP: if (tick) begin
          if (rx_s_q == SW'(SB_TICK-1)) rx_state_q <= S_IDLE;
          else                          rx_s_q     <= rx_s_q + SW'(1);
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  uart_ctrl_v2_fifo #(.W(DBIT+2), .AW(FIFO_W)) u_rx_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_i     (rx_push),
    .w_data_i ({rx_perr, rx_ferr, rx_b_q}),
    .rd_i     (rd_uart),
    .r_data_o (rx_head),
    .empty_o  (rx_empty),
    .full_o   (rx_full),
    .level_o  (rx_level)
  );

  assign r_data       = rx_head[DBIT-1:0];
  assign r_frame_err  = rx_head[DBIT];
  assign r_parity_err = rx_head[DBIT+1];

  // A new drop outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset)                              rx_overrun <= 1'b0;
    else if (rx_push && rx_full && !rd_uart) rx_overrun <= 1'b1;
    else if (clr_overrun)                   rx_overrun <= 1'b0;
  end

  // Transmitter
  state_e          tx_state_q;
  logic [SW-1:0]   tx_s_q;
  logic [NW-1:0]   tx_n_q;
  logic [DBIT-1:0] tx_b_q, tx_head;
  logic            tx_q, tx_busy_q, tx_empty, tx_pop, tx_stop_end;

  assign tx_stop_end = (tx_state_q == S_STOP) && tick && (tx_s_q == SW'(SB_TICK-1));
  assign tx_pop      = !tx_empty && ((tx_state_q == S_IDLE) || tx_stop_end);

`ifdef UART_PARITY_EN
  logic tx_par_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= S_IDLE;
      tx_s_q     <= '0;
      tx_n_q     <= '0;
      tx_b_q     <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else if (tx_pop) begin
      tx_state_q <= S_START;
      tx_s_q     <= '0;
      tx_b_q     <= tx_head;
      tx_q       <= 1'b0;
      tx_busy_q  <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= (^tx_head) ^ parity_odd;
`endif
    end else begin
      case (tx_state_q)
        S_IDLE: tx_busy_q <= 1'b0;
        S_START: if (tick) begin
          if (tx_s_q == SW'(15)) begin
            tx_s_q     <= '0;
            tx_n_q     <= '0;
            tx_q       <= tx_b_q[0];
            tx_state_q <= S_DATA;
          end else tx_s_q <= tx_s_q + SW'(1);
        end
        S_DATA: if (tick) begin
          if (tx_s_q == SW'(15)) begin
            tx_s_q <= '0;
            if (tx_n_q == NW'(DBIT-1)) begin
`ifdef UART_PARITY_EN
              tx_q       <= tx_par_q;
              tx_state_q <= S_PARITY;
`else
              tx_q       <= 1'b1;
              tx_state_q <= S_STOP;
`endif
            end else begin
              tx_n_q <= tx_n_q + NW'(1);
              tx_b_q <= tx_b_q >> 1;
              tx_q   <= tx_b_q[1];
            end
          end else tx_s_q <= tx_s_q + SW'(1);
        end
`ifdef UART_PARITY_EN
        S_PARITY: if (tick) begin
          if (tx_s_q == SW'(15)) begin
            tx_s_q     <= '0;
            tx_q       <= 1'b1;
            tx_state_q <= S_STOP;
          end else tx_s_q <= tx_s_q + SW'(1);
        end
`endif
        S_STOP: if (tick) begin
          if (tx_stop_end) begin
            tx_state_q <= S_IDLE;
            tx_busy_q  <= 1'b0;
          end else tx_s_q <= tx_s_q + SW'(1);
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  uart_ctrl_v2_fifo #(.W(DBIT), .AW(FIFO_W)) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_i     (wr_uart),
    .w_data_i (w_data),
    .rd_i     (tx_pop),
    .r_data_o (tx_head),
    .empty_o  (tx_empty),
    .full_o   (tx_full),
    .level_o  (tx_level)
  );

  assign tx      = tx_q;
  assign tx_busy = tx_busy_q;
endmodule
